// File: rtl/tjmono2_rx_align_ctrl.sv
// tjmono2_rx_align_ctrl: scans edges/taps for error-free windows and applies the centre of the longest one
module tjmono2_rx_align_ctrl #(
  parameter int NUM_TAPS = 32,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int DWELL_CYCLES = 65536,
  parameter int MIN_WINDOW = 3,
  localparam int TW = $clog2(NUM_TAPS),
  localparam int LW = $clog2(NUM_TAPS + 1)
) (
  input  logic          BUS_CLK,
  input  logic          BUS_RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic          RX_READY,
  input  logic [7:0]    DECODER_ERR_CNT,
  output logic [TW-1:0] DLY_VALUE,
  output logic          DLY_LOAD,
  output logic          SAMPLING_EDGE,
  output logic          RX_RESET,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic [TW-1:0] BEST_DLY,
  output logic          BEST_EDGE,
  output logic [LW-1:0] WINDOW_LEN
);
  localparam int M1 = SETTLE_CYCLES > LOCK_TIMEOUT ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC = M1 > DWELL_CYCLES ? M1 : DWELL_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, LOCK, DWELL, EVAL, APPLY, FINISH} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tap, cur_start, best_start, cur_start_n, best_start_n, center;
  logic [LW-1:0] cur_len, best_len, cur_len_n, best_len_n;
  logic [7:0] snap;
  logic edge_sel, best_edge, best_edge_n, tap_good, pulse, last_tap, last_dwell, upd, win_ok;
  assign BUSY = state != IDLE && state != FINISH;
  assign DLY_LOAD = pulse;
  assign RX_RESET = pulse;
  assign last_tap = tap == TW'(NUM_TAPS - 1);
  assign last_dwell = cnt == CW'(DWELL_CYCLES - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (START && !ABORT) ? LOAD : IDLE;
      LOAD:    nxt = SETTLE;
      SETTLE:  nxt = (cnt == CW'(SETTLE_CYCLES - 1)) ? LOCK : SETTLE;
      LOCK:    nxt = RX_READY ? DWELL : (cnt == CW'(LOCK_TIMEOUT - 1)) ? EVAL : LOCK;
      DWELL:   nxt = last_dwell ? EVAL : DWELL;
      EVAL:    nxt = (!last_tap || !edge_sel) ? LOAD : APPLY;
      APPLY:   nxt = FINISH;
      default: nxt = IDLE;
    endcase
    if (ABORT && BUSY) nxt = IDLE;
  end
  // Run-length update for the tap being evaluated; strict compare keeps the earliest window on ties
  always_comb begin
    cur_len_n = tap_good ? cur_len + 1'b1 : '0;
    cur_start_n = (tap_good && cur_len == '0) ? tap : cur_start;
    upd = cur_len_n > best_len;
    best_len_n = upd ? cur_len_n : best_len;
    best_start_n = upd ? cur_start_n : best_start;
    best_edge_n = upd ? edge_sel : best_edge;
    win_ok = best_len_n >= LW'(MIN_WINDOW);
    center = best_start_n + TW'((best_len_n - 1'b1) >> 1);
  end
  always_ff @(posedge BUS_CLK) state <= BUS_RST ? IDLE : nxt;
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      cnt <= '0;
      tap <= '0;
      edge_sel <= 1'b0;
      cur_len <= '0;
      cur_start <= '0;
      best_len <= '0;
      best_start <= '0;
      best_edge <= 1'b0;
      tap_good <= 1'b0;
      snap <= '0;
      pulse <= 1'b0;
      DLY_VALUE <= '0;
      SAMPLING_EDGE <= 1'b1;
      DONE <= 1'b0;
      FAIL <= 1'b0;
      BEST_DLY <= '0;
      BEST_EDGE <= 1'b0;
      WINDOW_LEN <= '0;
    end else begin
      cnt <= (nxt != state) ? '0 : cnt + 1'b1;
      pulse <= nxt == LOAD || nxt == APPLY;
      if (ABORT && BUSY) begin
        DONE <= 1'b0;
        FAIL <= 1'b0;
      end
      if (state == IDLE && nxt == LOAD) begin
        DONE <= 1'b0;
        FAIL <= 1'b0;
        tap <= '0;
        edge_sel <= 1'b0;
        cur_len <= '0;
        cur_start <= '0;
        best_len <= '0;
        best_start <= '0;
        best_edge <= 1'b0;
        DLY_VALUE <= '0;
        SAMPLING_EDGE <= 1'b0;
      end
      // A saturated counter cannot reveal new errors, so such a tap never counts as good
      if (state == LOCK) begin
        tap_good <= RX_READY && DECODER_ERR_CNT != 8'hFF;
        snap <= DECODER_ERR_CNT;
      end
      if (state == DWELL) tap_good <= tap_good && RX_READY && (!last_dwell || DECODER_ERR_CNT == snap);
      if (state == EVAL && nxt != IDLE) begin
        cur_start <= cur_start_n;
        best_len <= best_len_n;
        best_start <= best_start_n;
        best_edge <= best_edge_n;
        cur_len <= last_tap ? '0 : cur_len_n;
        tap <= last_tap ? '0 : tap + 1'b1;
        edge_sel <= edge_sel | last_tap;
        if (nxt == LOAD) begin
          DLY_VALUE <= last_tap ? '0 : tap + 1'b1;
          SAMPLING_EDGE <= edge_sel | last_tap;
        end else begin
          WINDOW_LEN <= best_len_n;
          DONE <= win_ok;
          FAIL <= !win_ok;
          BEST_DLY <= win_ok ? center : '0;
          BEST_EDGE <= win_ok & best_edge_n;
          DLY_VALUE <= win_ok ? center : '0;
          SAMPLING_EDGE <= !win_ok | best_edge_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_tjmono2_rx_align_ctrl.sv
// tb_tjmono2_rx_align_ctrl: directed scans against a tap-map receiver model with short timing parameters
module tb_tjmono2_rx_align_ctrl;
  logic BUS_CLK = 1'b0, BUS_RST = 1'b1, START = 1'b0, ABORT = 1'b0;
  wire rx_ready;
  wire [7:0] err_cnt;
  logic [4:0] dly_value, best_dly;
  logic [5:0] window_len;
  logic dly_load, sampling_edge, rx_reset, busy, done, fail, best_edge;
  int errors = 0, checks = 0;

  tjmono2_rx_align_ctrl #(.NUM_TAPS(32), .SETTLE_CYCLES(4), .LOCK_TIMEOUT(8), .DWELL_CYCLES(8), .MIN_WINDOW(3)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .START(START), .ABORT(ABORT),
    .RX_READY(rx_ready), .DECODER_ERR_CNT(err_cnt),
    .DLY_VALUE(dly_value), .DLY_LOAD(dly_load), .SAMPLING_EDGE(sampling_edge), .RX_RESET(rx_reset),
    .BUSY(busy), .DONE(done), .FAIL(fail), .BEST_DLY(best_dly), .BEST_EDGE(best_edge), .WINDOW_LEN(window_len)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Receiver model: locks on taps marked good, latches the tap on each load pulse
  logic [31:0] good0 = '0, good1 = '0;
  logic [4:0] rtap = '0, bump_tap = '0, drop_tap = '0;
  logic redge = 1'b0, bump_en = 1'b0, drop_en = 1'b0;
  logic [7:0] err_acc = 8'd3;
  int age = 0;
  always @(posedge BUS_CLK) begin
    if (dly_load) begin
      rtap <= dly_value;
      redge <= sampling_edge;
      age <= 0;
    end else age <= age + 1;
    if (bump_en && !redge && rtap == bump_tap && age == 8 && !dly_load) err_acc <= err_acc + 8'd1;
  end
  assign rx_ready = (redge ? good1[rtap] : good0[rtap]) && !(drop_en && !redge && rtap == drop_tap && age == 9);
  assign err_cnt = err_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dly_value"}, dly_value, 0);
    chk({tag, "_dly_load"}, dly_load, 0);
    chk({tag, "_edge"}, sampling_edge, 1);
    chk({tag, "_rx_reset"}, rx_reset, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_best_dly"}, best_dly, 0);
    chk({tag, "_best_edge"}, best_edge, 0);
    chk({tag, "_window_len"}, window_len, 0);
  endtask

  task automatic scan_expect(input string tag, input logic e_done, input logic e_edge,
                             input logic [4:0] e_dly, input logic [5:0] e_win,
                             input logic [4:0] e_ldv, input logic e_lse);
    int n = 0, loads = 0, resets = 0;
    logic [4:0] ldv = '0;
    logic lse = 1'b0;
    @(negedge BUS_CLK) START = 1'b1;
    @(negedge BUS_CLK) START = 1'b0;
    while (n < 5000) begin
      if (dly_load) begin
        loads++;
        ldv = dly_value;
        lse = sampling_edge;
      end
      if (rx_reset) resets++;
      if (!busy) break;
      n++;
      @(negedge BUS_CLK);
    end
    chk({tag, "_finished"}, n < 5000, 1);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_fail"}, fail, !e_done);
    chk({tag, "_best_edge"}, best_edge, e_edge);
    chk({tag, "_best_dly"}, best_dly, e_dly);
    chk({tag, "_window_len"}, window_len, e_win);
    chk({tag, "_loads"}, loads, 65);
    chk({tag, "_rx_resets"}, resets, 65);
    chk({tag, "_last_load_dly"}, ldv, e_ldv);
    chk({tag, "_last_load_edge"}, lse, e_lse);
    chk({tag, "_dly_value"}, dly_value, e_ldv);
    chk({tag, "_sampling_edge"}, sampling_edge, e_lse);
  endtask

  task automatic wait_load(input string tag, input logic [4:0] t, input logic e);
    int n = 0;
    while (!(dly_load && dly_value == t && sampling_edge == e) && n < 3000) begin
      @(negedge BUS_CLK);
      n++;
    end
    chk(tag, n < 3000, 1);
  endtask

  initial begin
    int stray;
    repeat (3) @(negedge BUS_CLK);
    chk_reset("reset");
    BUS_RST = 1'b0;
    @(negedge BUS_CLK) begin START = 1'b1; ABORT = 1'b1; end
    @(negedge BUS_CLK) begin START = 1'b0; ABORT = 1'b0; end
    chk("abort_start_busy", busy, 0);
    chk("abort_start_load", dly_load, 0);
    @(negedge BUS_CLK);
    chk("abort_start_busy2", busy, 0);

    good0 = 32'h0003_FC00; good1 = '0;
    scan_expect("single_window", 1, 0, 13, 8, 13, 0);
    good0 = 32'h0000_01F0; good1 = 32'h01F0_0000;
    scan_expect("tie", 1, 0, 6, 5, 6, 0);
    good1 = 32'h03F0_0000;
    scan_expect("edge1_wider", 1, 1, 22, 6, 22, 1);
    good0 = '0; good1 = '0;
    scan_expect("no_lock", 0, 0, 0, 0, 0, 1);
    good0 = 32'h8000_0003;
    scan_expect("no_wrap", 0, 0, 0, 2, 0, 1);
    good0 = 32'h0003_FC00; bump_en = 1'b1; bump_tap = 5'd14;
    scan_expect("err_bump", 1, 0, 11, 4, 11, 0);
    bump_en = 1'b0; drop_en = 1'b1; drop_tap = 5'd12;
    scan_expect("ready_drop", 1, 0, 15, 5, 15, 0);
    drop_en = 1'b0;

    @(negedge BUS_CLK) START = 1'b1;
    @(negedge BUS_CLK) START = 1'b0;
    chk("scan_clears_done", done, 0);
    wait_load("wait_tap5", 5'd5, 1'b0);
    @(negedge BUS_CLK) ABORT = 1'b1;
    @(negedge BUS_CLK) ABORT = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fail", fail, 0);
    chk("abort_dly_value", dly_value, 5);
    chk("abort_edge", sampling_edge, 0);
    stray = 0;
    repeat (20) begin
      if (dly_load || rx_reset) stray++;
      @(negedge BUS_CLK);
    end
    chk("abort_no_pulses", stray, 0);
    chk("abort_keeps_dly", dly_value, 5);

    @(negedge BUS_CLK) START = 1'b1;
    @(negedge BUS_CLK) START = 1'b0;
    chk("restart_load", dly_load, 1);
    chk("restart_tap", dly_value, 0);
    chk("restart_edge", sampling_edge, 0);
    chk("restart_busy", busy, 1);
    wait_load("wait_tap11", 5'd11, 1'b0);
    repeat (7) @(negedge BUS_CLK);
    chk("dwell_busy", busy, 1);
    BUS_RST = 1'b1;
    @(negedge BUS_CLK);
    chk_reset("mid_dwell_reset");
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);
    chk("post_reset_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
